ham_link_ctrl: RTL and testbench

- Transmit scheduler and link monitor for the serial Hamming (7,4) FSK link.
- Shares the single nibble ENCODER between two requesters, using a round-robin valid/ready handshake.
- Sequences the encoder in fixed codeword slots: a load pulse, then CODE_LEN serial bit periods, then an idle guard gap.
- Counts decoder error flags for link-quality statistics.

---
 rtl/ham_link_pkg.sv | 26 ++
 rtl/ham_link_ctrl_rr_arb2.sv | 28 ++
 rtl/ham_link_ctrl.sv | 151 +++++++++++++++
 tb/tb_ham_link_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_link_pkg.sv
// ham_link_pkg
// Shared definitions for the Hamming (7,4) FSK link transmit controller:
// TX sequencer state encoding, nibble width, default slot timing and the
// helper that sizes the slot counter from the chosen timing parameters.
package ham_link_pkg;

  localparam int NIBBLE_W     = 4;
  localparam int DEF_CODE_LEN = 7;
  localparam int DEF_GAP_LEN  = 2;

  // TX sequencer states: wait for a requester, serialise, guard gap
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // The slot counter runs 0..len-1 for both the SEND and GAP phases, so it
  // only needs enough bits for the longer of the two minus one.
  function automatic int cnt_width(input int code_len, input int gap_len);
    int max_len;
    max_len = (code_len > gap_len) ? code_len : gap_len;
    return (max_len <= 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/ham_link_ctrl_rr_arb2.sv
// rr_arb2
// Two-request round-robin arbiter. Purely combinational; the caller owns
// the last_grant history bit and updates it when a grant is consumed.
// Ports:
//   req[1:0]    request lines (bit n = requester n)
//   last_grant  requester that won the previous transfer
//   enable      grants are only issued while enable is high
//   gnt[1:0]    one-hot grant (all zero when disabled or no request)
//   gnt_id      index of the winning requester
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // A lone requester always wins; under contention the one that did not
  // win last time goes next, which yields strict alternation.
  always_comb begin
    gnt_id = (req == 2'b11) ? ~last_grant : req[1];
    gnt    = 2'b00;
    if (enable && (req != 2'b00)) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ham_link_ctrl.sv
// ham_link_ctrl
// Transmit scheduler and link monitor for the serial Hamming (7,4) FSK link.
// Two requesters share one nibble encoder through a round-robin valid/ready
// handshake. Each accepted nibble occupies a fixed slot: one load strobe,
// CODE_LEN serial bit periods, then GAP_LEN guard cycles. Decoder error
// flags are counted independently of the transmit side.
// Ports:
//   clk, reset                 clock, async active-high reset
//   req0_valid/data/ready      requester 0 handshake
//   req1_valid/data/ready      requester 1 handshake
//   enc_data, enc_load         nibble and latch strobe to the encoder
//   tx_active                  high while a codeword is being serialised
//   grant_id                   owner of the current or most recent slot
//   dec_valid, dec_wrong       decoder word-valid and WRONG flag
//   clr_stats                  synchronous clear of err_cnt
//   err_cnt                    saturating decoder error count
module ham_link_ctrl
  import ham_link_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [NIBBLE_W-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [NIBBLE_W-1:0] req1_data,
  output logic                req1_ready,
  output logic [NIBBLE_W-1:0] enc_data,
  output logic                enc_load,
  output logic                tx_active,
  output logic                grant_id,
  input  logic                dec_valid,
  input  logic                dec_wrong,
  input  logic                clr_stats,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int CNT_W = cnt_width(CODE_LEN, GAP_LEN);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_enable;
  logic             accept;

  // Grants are only offered in IDLE. Reset is folded in as well so that a
  // requester never sees ready while the controller is held in reset.
  assign arb_enable = (state_q == IDLE) && !reset;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_enable),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  // The arbiter only raises a grant for a valid requester, so any grant is
  // a completed valid&&ready transfer.
  assign accept = |gnt;

  // State register: sequencer state and the shared slot counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter restarts from zero on every phase change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q == SEND_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_LEN > 0) ? GAP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: decoded from registered state so that reset drops them
  // immediately and a reset mid-slot can never leave a partial load strobe.
  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    enc_load   = (state_q == SEND) && (cnt_q == '0);
    tx_active  = (state_q == SEND);
  end

  // Accepted nibble and grant history. last_grant resets to 1 so that
  // requester 0 wins the first contended slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_data     <= '0;
      grant_id     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      enc_data     <= gnt_id ? req1_data : req0_data;
      grant_id     <= gnt_id;
      last_grant_q <= gnt_id;
    end
  end

  // Decoder error statistics: clear wins over a same-cycle increment and
  // the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr_stats) begin
      err_cnt <= '0;
    end else if (dec_valid && dec_wrong && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_link_ctrl.sv
// tb_ham_link_ctrl
// Directed self-checking bench for ham_link_ctrl at default parameters.
// Expected encoder words are pushed to a scoreboard when stimulus is
// driven and popped when the controller issues its load strobe.
module tb_ham_link_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [3:0] enc_data;
  logic       enc_load, tx_active, grant_id;
  logic       dec_valid, dec_wrong, clr_stats;
  logic [7:0] err_cnt;

  typedef struct packed {
    logic       gid;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   cyc       = 0;
  int   exp_err   = 0;
  logic model_last;

  ham_link_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .enc_data   (enc_data),
    .enc_load   (enc_load),
    .tx_active  (tx_active),
    .grant_id   (grant_id),
    .dec_valid  (dec_valid),
    .dec_wrong  (dec_wrong),
    .clr_stats  (clr_stats),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive both requesters, then let combinational ready settle
  task automatic apply_stimulus(input logic v0, input logic [3:0] d0,
                                input logic v1, input logic [3:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
  endtask

  task automatic push_exp(input logic gid, input logic [3:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next enc_load, then compare against the scoreboard
  task automatic wait_load(input string tag, output int waited);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      waited++;
      if (enc_load === 1'b1) seen = 1'b1;
    end
    check_output({tag, "_load_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_output({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output({tag, "_enc_data"}, 32'(enc_data), 32'(e.data));
        check_output({tag, "_grant_id"}, 32'(grant_id), 32'(e.gid));
        check_output({tag, "_tx_active"}, 32'(tx_active), 32'd1);
      end
    end
  endtask

  initial begin
    int   w;
    int   prev_cyc;
    logic win;

    reset      = 1'b1;
    dec_valid  = 1'b0;
    dec_wrong  = 1'b0;
    clr_stats  = 1'b0;
    model_last = 1'b1;
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    repeat (3) tick();
    check_output("reset_outs", {tx_active, enc_load, req0_ready, req1_ready, grant_id, enc_data}, 32'd0);
    check_output("reset_err", 32'(err_cnt), 32'd0);

    // Idle after reset release
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("idle_outs", {tx_active, enc_load, req0_ready, req1_ready, grant_id, enc_data}, 32'd0);
      check_output("idle_err", 32'(err_cnt), 32'd0);
    end

    // Single request from requester 0
    apply_stimulus(1'b1, 4'b1011, 1'b0, 4'h0);
    check_output("single_ready0", 32'(req0_ready), 32'd1);
    check_output("single_ready1", 32'(req1_ready), 32'd0);
    push_exp(1'b0, 4'b1011);
    model_last = 1'b0;
    wait_load("single", w);
    check_output("single_latency", 32'(w), 32'd1);
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      check_output("single_tx", 32'(tx_active), 32'd1);
      check_output("single_load", 32'(enc_load), 32'(i == 0));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check_output("single_gap", {tx_active, enc_load, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    check_output("single_idle", {tx_active, enc_load}, 32'd0);

    // Continuous contention: strict alternation, fixed slot period
    apply_stimulus(1'b1, 4'b1011, 1'b1, 4'b0111);
    check_output("cont_ready0", 32'(req0_ready), 32'(model_last == 1'b1));
    check_output("cont_ready1", 32'(req1_ready), 32'(model_last == 1'b0));
    for (int k = 0; k < 4; k++) begin
      win = ~model_last;
      push_exp(win, win ? 4'b0111 : 4'b1011);
      model_last = win;
    end
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_load("cont", w);
      if (k > 0) check_output("cont_period", 32'(cyc - prev_cyc), 32'd10);
      prev_cyc = cyc;
    end
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    repeat (10) tick();

    // Requester 1 arrives while requester 0's word is in flight
    apply_stimulus(1'b1, 4'b0011, 1'b0, 4'h0);
    push_exp(1'b0, 4'b0011);
    model_last = 1'b0;
    wait_load("mid_first", w);
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    tick();
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'b1100);
    push_exp(1'b1, 4'b1100);
    model_last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_output("mid_ready1_low", 32'(req1_ready), 32'd0);
      tick();
    end
    check_output("mid_ready1_high", 32'(req1_ready), 32'd1);
    wait_load("mid_second", w);
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    repeat (10) tick();

    // Decoder error statistics
    dec_valid = 1'b1;
    dec_wrong = 1'b1;
    repeat (3) begin
      tick();
      exp_err++;
    end
    dec_valid = 1'b0;
    dec_wrong = 1'b0;
    check_output("err_three", 32'(err_cnt), 32'(exp_err));
    dec_wrong = 1'b1;
    repeat (2) tick();
    dec_wrong = 1'b0;
    check_output("err_wrong_only", 32'(err_cnt), 32'(exp_err));
    dec_valid = 1'b1;
    tick();
    dec_valid = 1'b0;
    check_output("err_valid_only", 32'(err_cnt), 32'(exp_err));
    dec_valid = 1'b1;
    dec_wrong = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_err < 255) exp_err++;
      if (i == 100) check_output("err_climb", 32'(err_cnt), 32'(exp_err));
    end
    check_output("err_saturate", 32'(err_cnt), 32'(exp_err));
    clr_stats = 1'b1;
    tick();
    exp_err   = 0;
    clr_stats = 1'b0;
    dec_valid = 1'b0;
    dec_wrong = 1'b0;
    check_output("err_clr_priority", 32'(err_cnt), 32'(exp_err));
    dec_valid = 1'b1;
    dec_wrong = 1'b1;
    tick();
    exp_err++;
    dec_valid = 1'b0;
    dec_wrong = 1'b0;
    check_output("err_after_clr", 32'(err_cnt), 32'(exp_err));

    // Reset during the fourth SEND cycle
    apply_stimulus(1'b1, 4'b1011, 1'b1, 4'b0111);
    check_output("rst_pre_ready0", 32'(req0_ready), 32'(model_last == 1'b1));
    check_output("rst_pre_ready1", 32'(req1_ready), 32'(model_last == 1'b0));
    push_exp(~model_last, (~model_last) ? 4'b0111 : 4'b1011);
    model_last = ~model_last;
    wait_load("rst_pre", w);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_output("rst_mid_outs", {tx_active, enc_load, req0_ready, req1_ready, grant_id, enc_data}, 32'd0);
    check_output("rst_mid_err", 32'(err_cnt), 32'd0);
    model_last = 1'b1;
    repeat (2) tick();
    check_output("rst_held_outs", {tx_active, enc_load, req0_ready, req1_ready, grant_id, enc_data}, 32'd0);
    reset = 1'b0;
    #1;
    check_output("rst_post_ready0", 32'(req0_ready), 32'd1);
    check_output("rst_post_ready1", 32'(req1_ready), 32'd0);
    push_exp(1'b0, 4'b1011);
    model_last = 1'b0;
    wait_load("rst_post", w);
    check_output("rst_post_latency", 32'(w), 32'd1);
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'b0111);
    push_exp(1'b1, 4'b0111);
    model_last = 1'b1;
    wait_load("rst_req1", w);
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    repeat (12) tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
